reaction_round_ctrl: RTL

Round sequencer for the two-player reaction timer. It arms a pseudo-random wait, lights the GO lamp, and drives enable and clear to the shared millisecond counter. It decides which player pressed first, detects false starts and publishes one registered result per round. It sits between the debounced key pulses and the display/score-keeping logic, and replaces ad-hoc keypress decoding for the start/stop path.

---
 rtl/reaction_round_ctrl_pkg.sv | 26 ++
 rtl/reaction_round_ctrl_lfsr.sv | 26 ++
 rtl/reaction_round_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/reaction_round_ctrl_pkg.sv
// Shared state encoding, winner codes and LFSR constants for the
// reaction-timer round sequencer.
package reaction_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_GO    = 3'd2,
        ST_DONE  = 3'd3,
        ST_FOUL  = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_TIE  = 2'd3;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps at bits 7,5,4,3 realise x^8+x^6+x^5+x^4+1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_round_ctrl_lfsr.sv
// rc_lfsr8: free-running 8-bit Fibonacci LFSR, steps every clock.
module rc_lfsr8
    import reaction_round_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr_q
);

    logic [7:0] lfsr_d;

    // Next LFSR value from the shared polynomial helper.
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/reaction_round_ctrl.sv
// Round sequencer for the two-player reaction timer.
// Optional false-start detection is built when ROUND_CTRL_FOUL_EN is defined.
module reaction_round_ctrl
    import reaction_round_ctrl_pkg::*;
#(
    parameter int CNT_W   = 10,
    parameter int DLY_MIN = 500,
    parameter int DLY_RW  = 8,
    parameter int TIMEOUT = 999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start_key,
    input  logic             p1_key,
    input  logic             p2_key,
    output logic             lamp,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             res_valid,
    output logic [1:0]       winner,
    output logic [CNT_W-1:0] react_ms,
    output logic [1:0]       foul,
    output logic [4:0]       rounds
);

    localparam int WAIT_W = $clog2(DLY_MIN + (1 << DLY_RW));
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [7:0]        lfsr_s;
    logic [1:0]        keys_s;
    logic              enter_arm_s;
    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  ms_q, ms_d;
    logic              lamp_q, lamp_d, cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d;
    logic              busy_q, busy_d, res_valid_q, res_valid_d;
    logic [1:0]        winner_q, winner_d, foul_q, foul_d;
    logic [CNT_W-1:0]  react_ms_q, react_ms_d;
    logic [4:0]        rounds_q, rounds_d;

    assign keys_s = {p2_key, p1_key};

    rc_lfsr8 u_lfsr (
        .clk    (clk),
        .rst_n  (rst),
        .lfsr_q (lfsr_s)
    );

    // Next-state, counter and result computation.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        ms_d        = ms_q;
        lamp_d      = lamp_q;
        cnt_en_d    = cnt_en_q;
        cnt_clr_d   = 1'b0;
        busy_d      = busy_q;
        res_valid_d = 1'b0;
        winner_d    = winner_q;
        react_ms_d  = react_ms_q;
        foul_d      = foul_q;
        rounds_d    = rounds_q;
        enter_arm_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                enter_arm_s = start_key;
            end
            ST_ARMED: begin
`ifdef ROUND_CTRL_FOUL_EN
                // A key on the final wait tick still counts as a false start.
                if (keys_s != 2'b00) begin
                    state_d     = ST_FOUL;
                    foul_d      = keys_s;
                    busy_d      = 1'b0;
                    res_valid_d = 1'b1;
                    rounds_d    = rounds_q + 5'd1;
                end else
`endif
                if (tick) begin
                    wait_d = wait_q - WAIT_W'(1);
                    if (wait_q <= WAIT_W'(1)) begin
                        state_d  = ST_GO;
                        lamp_d   = 1'b1;
                        cnt_en_d = 1'b1;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end else begin
                    wait_d = wait_q;
                end
            end
            ST_GO: begin
                // A press on the timeout tick wins over the timeout.
                if ((keys_s != 2'b00) || (tick && (ms_q == TIMEOUT_C))) begin
                    state_d     = ST_DONE;
                    lamp_d      = 1'b0;
                    cnt_en_d    = 1'b0;
                    busy_d      = 1'b0;
                    res_valid_d = 1'b1;
                    rounds_d    = rounds_q + 5'd1;
                    if (keys_s != 2'b00) begin
                        winner_d   = keys_s;
                        react_ms_d = ms_q;
                    end else begin
                        winner_d   = WIN_NONE;
                        react_ms_d = TIMEOUT_C;
                    end
                end else if (tick) begin
                    ms_d = ms_q + CNT_W'(1);
                end else begin
                    ms_d = ms_q;
                end
            end
            ST_DONE: begin
                enter_arm_s = start_key;
            end
`ifdef ROUND_CTRL_FOUL_EN
            ST_FOUL: begin
                enter_arm_s = start_key;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_arm_s) begin
            state_d    = ST_ARMED;
            wait_d     = WAIT_W'(DLY_MIN) + WAIT_W'(lfsr_s[DLY_RW-1:0]);
            ms_d       = '0;
            cnt_clr_d  = 1'b1;
            busy_d     = 1'b1;
            winner_d   = WIN_NONE;
            react_ms_d = '0;
            foul_d     = 2'b00;
        end else begin
            cnt_clr_d = cnt_clr_d;
        end
    end

    // State, counter and registered-output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            ms_q        <= '0;
            lamp_q      <= 1'b0;
            cnt_en_q    <= 1'b0;
            cnt_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            winner_q    <= WIN_NONE;
            react_ms_q  <= '0;
            foul_q      <= 2'b00;
            rounds_q    <= 5'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            ms_q        <= ms_d;
            lamp_q      <= lamp_d;
            cnt_en_q    <= cnt_en_d;
            cnt_clr_q   <= cnt_clr_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            winner_q    <= winner_d;
            react_ms_q  <= react_ms_d;
            foul_q      <= foul_d;
            rounds_q    <= rounds_d;
        end
    end

    assign lamp      = lamp_q;
    assign cnt_en    = cnt_en_q;
    assign cnt_clr   = cnt_clr_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign winner    = winner_q;
    assign react_ms  = react_ms_q;
    assign foul      = foul_q;
    assign rounds    = rounds_q;

endmodule
